// File: rtl/vec_mul_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : vec_mul_sequencer_pkg
//  Description : Shared constants for the vector-multiply run controller:
//                state encoding and default geometry.
//  Revision    : 1.0 - initial release
// ============================================================================
package vec_mul_sequencer_pkg;

    localparam int c_DEF_ADDRESSSIZE  = 10;
    localparam int c_DEF_PIPE_LATENCY = 2;

    localparam int c_STATE_W = 3;

    localparam logic [c_STATE_W-1:0] c_IDLE   = 3'd0;
    localparam logic [c_STATE_W-1:0] c_WREQ   = 3'd1;
    localparam logic [c_STATE_W-1:0] c_WLOAD  = 3'd2;
    localparam logic [c_STATE_W-1:0] c_STREAM = 3'd3;
    localparam logic [c_STATE_W-1:0] c_DRAIN  = 3'd4;
    localparam logic [c_STATE_W-1:0] c_DONE   = 3'd5;

endpackage
`default_nettype wire

// File: rtl/vec_mul_sequencer_valid_delay_line.sv
`default_nettype none
// ============================================================================
//  Module      : valid_delay_line
//  Description : DEPTH-deep 1-bit shift register tracking issued vectors
//                through the datapath, with synchronous flush and an
//                "anything in flight" flag.
//  Revision    : 1.0 - initial release
// ============================================================================
module valid_delay_line #(
    parameter int DEPTH = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic i_flush,
    input  logic i_valid,
    output logic o_valid,
    output logic o_any_valid
);

    logic [DEPTH-1:0] r_stages;

    // Shift the valid bit one stage per cycle; flush empties every stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stages <= '0;
        end else if (i_flush) begin
            r_stages <= '0;
        end else begin
            r_stages[0] <= i_valid;
            for (int i = 1; i < DEPTH; i++) begin
                r_stages[i] <= r_stages[i-1];
            end
        end
    end

    assign o_valid     = r_stages[DEPTH-1];
    assign o_any_valid = |r_stages;

endmodule
`default_nettype wire

// File: rtl/vec_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : vec_mul_sequencer
//  Description : Run controller for the vector-multiply datapath. Loads one
//                weight tile (unless reusing), streams N UB addresses, tracks
//                datapath latency and writes N results, then pulses done.
//  Revision    : 1.0 - initial release
// ============================================================================
module vec_mul_sequencer
    import vec_mul_sequencer_pkg::*;
#(
    parameter int ADDRESSSIZE  = c_DEF_ADDRESSSIZE,
    parameter int PIPE_LATENCY = c_DEF_PIPE_LATENCY
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic                   abort,
    input  logic [ADDRESSSIZE-1:0] cfg_src_base,
    input  logic [ADDRESSSIZE-1:0] cfg_dst_base,
    input  logic [ADDRESSSIZE-1:0] cfg_num_vec,
    input  logic                   cfg_reuse_weights,
    input  logic                   fifo_empty,
    output logic                   fifo_read_enable,
    output logic                   weight_reload,
    output logic [ADDRESSSIZE-1:0] ub_address,
    output logic                   ub_issue,
    output logic                   res_write_enable,
    output logic [ADDRESSSIZE-1:0] res_address,
    output logic                   busy,
    output logic                   done
);

    logic [c_STATE_W-1:0]   r_state;
    logic [c_STATE_W-1:0]   w_next_state;

    logic [ADDRESSSIZE-1:0] r_src;
    logic [ADDRESSSIZE-1:0] r_dst;
    logic [ADDRESSSIZE-1:0] r_num;
    logic [ADDRESSSIZE-1:0] r_cnt;
    logic [ADDRESSSIZE-1:0] r_wr_idx;

    logic                   w_start_acc;
    logic                   w_flush;
    logic                   w_pipe_out;
    logic                   w_any_valid;

    // Abort is a no-op in IDLE, so start in IDLE is always accepted.
    assign w_start_acc = (r_state == c_IDLE) && start;
    assign w_flush     = abort && (r_state != c_IDLE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; abort outranks every other transition.
    always_comb begin
        w_next_state = r_state;
        if (w_flush) begin
            w_next_state = c_IDLE;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        if (!cfg_reuse_weights) begin
                            w_next_state = c_WREQ;
                        end else if (cfg_num_vec == '0) begin
                            w_next_state = c_DONE;
                        end else begin
                            w_next_state = c_STREAM;
                        end
                    end
                end
                c_WREQ:   if (!fifo_empty) w_next_state = c_WLOAD;
                c_WLOAD:  w_next_state = (r_num == '0) ? c_DONE : c_STREAM;
                c_STREAM: if (r_cnt == r_num - 1'b1) w_next_state = c_DRAIN;
                c_DRAIN:  if (!w_any_valid) w_next_state = c_DONE;
                c_DONE:   w_next_state = c_IDLE;
                default:  w_next_state = c_IDLE;
            endcase
        end
    end

    // State-decoded outputs; addresses are forced to zero when not valid.
    always_comb begin
        fifo_read_enable = (r_state == c_WREQ) && !fifo_empty && !abort;
        weight_reload    = (r_state == c_WLOAD);
        ub_issue         = (r_state == c_STREAM);
        ub_address       = ub_issue ? (r_src + r_cnt) : '0;
        res_write_enable = w_pipe_out;
        res_address      = w_pipe_out ? (r_dst + r_wr_idx) : '0;
        busy             = (r_state != c_IDLE);
        done             = (r_state == c_DONE);
    end

    // Configuration capture at start, issue and write index counters.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src    <= '0;
            r_dst    <= '0;
            r_num    <= '0;
            r_cnt    <= '0;
            r_wr_idx <= '0;
        end else if (w_start_acc) begin
            r_src    <= cfg_src_base;
            r_dst    <= cfg_dst_base;
            r_num    <= cfg_num_vec;
            r_cnt    <= '0;
            r_wr_idx <= '0;
        end else begin
            if (r_state == c_STREAM) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_pipe_out) begin
                r_wr_idx <= r_wr_idx + 1'b1;
            end
        end
    end

    valid_delay_line #(
        .DEPTH(PIPE_LATENCY)
    ) u_valid_delay_line (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (w_flush),
        .i_valid    (ub_issue),
        .o_valid    (w_pipe_out),
        .o_any_valid(w_any_valid)
    );

endmodule
`default_nettype wire

// File: tb/tb_vec_mul_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vec_mul_sequencer
//  Description : Directed self-checking bench for vec_mul_sequencer.
//                Each run is described by its hand-derived timeline (pop,
//                reload, first issue and done cycles) relative to the start
//                cycle; every cycle's outputs are compared against it.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_vec_mul_sequencer;

    localparam int c_AW  = 10;
    localparam int c_LAT = 2;

    logic            clk;
    logic            rst;
    logic            start;
    logic            abort;
    logic [c_AW-1:0] cfg_src_base;
    logic [c_AW-1:0] cfg_dst_base;
    logic [c_AW-1:0] cfg_num_vec;
    logic            cfg_reuse_weights;
    logic            fifo_empty;
    logic            fifo_read_enable;
    logic            weight_reload;
    logic [c_AW-1:0] ub_address;
    logic            ub_issue;
    logic            res_write_enable;
    logic [c_AW-1:0] res_address;
    logic            busy;
    logic            done;

    int n_tests = 0;
    int n_fail  = 0;

    vec_mul_sequencer #(
        .ADDRESSSIZE (c_AW),
        .PIPE_LATENCY(c_LAT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .start            (start),
        .abort            (abort),
        .cfg_src_base     (cfg_src_base),
        .cfg_dst_base     (cfg_dst_base),
        .cfg_num_vec      (cfg_num_vec),
        .cfg_reuse_weights(cfg_reuse_weights),
        .fifo_empty       (fifo_empty),
        .fifo_read_enable (fifo_read_enable),
        .weight_reload    (weight_reload),
        .ub_address       (ub_address),
        .ub_issue         (ub_issue),
        .res_write_enable (res_write_enable),
        .res_address      (res_address),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed vector: {pop, reload, issue, ub_addr, we, res_addr, busy, done}
    function automatic logic [25:0] obs_vec();
        return {fifo_read_enable, weight_reload, ub_issue, ub_address,
                res_write_enable, res_address, busy, done};
    endfunction

    task automatic check(input string tag, input int c, input logic [25:0] exp);
        logic [25:0] obs;
        obs = obs_vec();
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, c, obs, exp);
        end
    endtask

    // One run. Cycle 0 is the cycle start is driven. Timeline arguments are
    // hand-derived; -1 disables an event. cfg inputs are scrambled from
    // cycle 1 onward so any late sampling shows up.
    task automatic run(input string tag,
                       input int src, input int dst, input int n, input bit reuse,
                       input int stall, input int pop_c, input int rel_c,
                       input int iss_c, input int done_c, input int last_c,
                       input int poke_c, input int abort_c, input int rst_c);
        logic            e_pop, e_rel, e_iss, e_we, e_busy, e_done, killed;
        logic [c_AW-1:0] e_ua, e_ra;
        @(posedge clk); #1;
        start             = 1'b1;
        cfg_src_base      = c_AW'(src);
        cfg_dst_base      = c_AW'(dst);
        cfg_num_vec       = c_AW'(n);
        cfg_reuse_weights = reuse;
        fifo_empty        = (stall > 0);
        #1;
        check(tag, 0, '0);
        for (int c = 1; c <= last_c; c++) begin
            @(posedge clk); #1;
            start             = (c == poke_c);
            cfg_src_base      = 10'h155;
            cfg_dst_base      = 10'h2AA;
            cfg_num_vec       = 10'h007;
            cfg_reuse_weights = ~reuse;
            fifo_empty        = (c <= stall);
            abort             = (c == abort_c);
            rst               = (c == rst_c);
            #1;
            killed = ((abort_c >= 0) && (c > abort_c)) || ((rst_c >= 0) && (c >= rst_c));
            e_pop  = (c == pop_c);
            e_rel  = (c == rel_c);
            e_iss  = (c >= iss_c) && (c < iss_c + n);
            e_we   = (c >= iss_c + c_LAT) && (c < iss_c + c_LAT + n);
            e_ua   = e_iss ? c_AW'(src + c - iss_c) : '0;
            e_ra   = e_we ? c_AW'(dst + c - iss_c - c_LAT) : '0;
            e_busy = (c <= done_c);
            e_done = (c == done_c);
            if (killed)
                check(tag, c, '0);
            else
                check(tag, c, {e_pop, e_rel, e_iss, e_ua, e_we, e_ra, e_busy, e_done});
        end
        start = 1'b0;
        abort = 1'b0;
        rst   = 1'b0;
    endtask

    initial begin
        rst               = 1'b1;
        start             = 1'b0;
        abort             = 1'b0;
        cfg_src_base      = '0;
        cfg_dst_base      = '0;
        cfg_num_vec       = '0;
        cfg_reuse_weights = 1'b0;
        fifo_empty        = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset", 0, '0);
        rst = 1'b0;

        //  tag          src     dst     n  reuse stall pop rel iss done last poke abort rst
        run("basic",     'h010, 'h200,  4, 1'b0, 0,    1,  2,  3,  10,  12,  -1,  -1,  -1);
        run("stall",     'h010, 'h200,  4, 1'b0, 5,    6,  7,  8,  15,  17,  -1,  -1,  -1);
        run("reuse3",    'h040, 'h100,  3, 1'b1, 0,   -1, -1,  1,   7,   9,  -1,  -1,  -1);
        run("zero_n",    'h040, 'h100,  0, 1'b0, 0,    1,  2, -1,   3,   5,  -1,  -1,  -1);
        run("reuse_0",   'h040, 'h100,  0, 1'b1, 0,   -1, -1, -1,   1,   3,  -1,  -1,  -1);
        run("wrap",      'h3FE, 'h3FF,  3, 1'b0, 0,    1,  2,  3,   9,  11,  -1,  -1,  -1);
        run("abort",     'h010, 'h200,  4, 1'b0, 0,    1,  2,  3,  10,  12,  -1,   4,  -1);
        run("rst_drain", 'h010, 'h200,  4, 1'b0, 0,    1,  2,  3,  10,  11,  -1,  -1,   8);
        run("after_rst", 'h020, 'h300,  4, 1'b0, 0,    1,  2,  3,  10,  12,  -1,  -1,  -1);
        run("start_busy",'h010, 'h200,  4, 1'b0, 0,    1,  2,  3,  10,  12,   4,  -1,  -1);
        run("start_done",'h010, 'h200,  4, 1'b0, 0,    1,  2,  3,  10,  13,  10,  -1,  -1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
